puf_response_collector: RTL

Measurement controller that drives a pair of post-mux counters and turns their results into a PUF response word. On `start` it steps through N_BITS oscillator pairs. For each pair it clears and enables the counters, waits for both `finished` flags, and compares the two counts to produce one response bit. It sits above the post-mux counters: it drives their `enable`/`reset` and consumes their `out`/`finished`.

---
 rtl/puf_response_collector_if.sv | 25 ++
 rtl/puf_response_collector.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/puf_response_collector_if.sv
// Counter-side bundle of the PUF response collector: the collector drives
// the reset/enable/pair-select of the two post-mux counters and reads back
// their counts and finished flags.
interface puf_response_collector_if #(
   parameter int N_BITS = 8,
   parameter int CNT_W  = 8
);
   logic                      cnt_reset;
   logic                      cnt_enable;
   logic [$clog2(N_BITS)-1:0] pair_idx;
   logic [CNT_W-1:0]          cnt_a_out;
   logic                      cnt_a_fin;
   logic [CNT_W-1:0]          cnt_b_out;
   logic                      cnt_b_fin;

   modport master (
      output cnt_reset, cnt_enable, pair_idx,
      input  cnt_a_out, cnt_a_fin, cnt_b_out, cnt_b_fin
   );

   modport slave (
      input  cnt_reset, cnt_enable, pair_idx,
      output cnt_a_out, cnt_a_fin, cnt_b_out, cnt_b_fin
   );
endinterface

// File: rtl/puf_response_collector.sv
// PUF response collector: measures N_BITS oscillator pairs one after the
// other through a shared pair of post-mux counters and builds one response
// bit per pair from an unsigned comparison of the two counts.
module puf_response_collector #(
   parameter int N_BITS  = 8,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_err,
   output logic [N_BITS-1:0]        response,
   output logic [$clog2(N_BITS):0]  tie_count,
   puf_response_collector_if.master cnt
);

   localparam int IDX_W = $clog2(N_BITS);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      COMPARE,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] pair_idx;
   logic [CNT_W-1:0] latch_a;
   logic [CNT_W-1:0] latch_b;
   logic             seen_a;
   logic             seen_b;
   logic             in_reset;
   logic [TMO_W-1:0] tmo_cnt;
   logic             both_fin;
   logic             tmo_hit;
   logic             last_pair;

   // A flag counts as finished if it was latched earlier or is high right now,
   // so simultaneous flags are accepted in the same RUN cycle.
   always_comb begin
      both_fin  = (seen_a | cnt.cnt_a_fin) & (seen_b | cnt.cnt_b_fin);
      tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT));
      last_pair = (pair_idx == IDX_W'(N_BITS - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode and state-driven outputs; counters stay in reset while our own reset is active.
   always_comb begin
      state_next     = state;
      cnt.cnt_reset  = in_reset;
      cnt.cnt_enable = 1'b0;
      cnt.pair_idx   = pair_idx;
      busy           = (state != IDLE);
      done           = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CLEAR;
         end
         CLEAR: begin
            cnt.cnt_reset = 1'b1;
            state_next    = RUN;
         end
         RUN: begin
            cnt.cnt_enable = 1'b1;
            if (both_fin)     state_next = COMPARE;
            else if (tmo_hit) state_next = DONE;
         end
         COMPARE: begin
            state_next = last_pair ? DONE : CLEAR;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: per-run results, pair index, first-seen count latches and the RUN timeout counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_reset    <= 1'b1;
         pair_idx    <= '0;
         response    <= '0;
         tie_count   <= '0;
         timeout_err <= 1'b0;
         latch_a     <= '0;
         latch_b     <= '0;
         seen_a      <= 1'b0;
         seen_b      <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         in_reset <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pair_idx    <= '0;
                  response    <= '0;
                  tie_count   <= '0;
                  timeout_err <= 1'b0;
               end
            end
            CLEAR: begin
               seen_a  <= 1'b0;
               seen_b  <= 1'b0;
               tmo_cnt <= '0;
            end
            RUN: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (!seen_a && cnt.cnt_a_fin) begin
                  latch_a <= cnt.cnt_a_out;
                  seen_a  <= 1'b1;
               end
               if (!seen_b && cnt.cnt_b_fin) begin
                  latch_b <= cnt.cnt_b_out;
                  seen_b  <= 1'b1;
               end
               if (!both_fin && tmo_hit) timeout_err <= 1'b1;
            end
            COMPARE: begin
               response[pair_idx] <= (latch_a > latch_b);
               if (latch_a == latch_b) tie_count <= tie_count + 1'b1;
               if (!last_pair) pair_idx <= pair_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
